// File: rtl/rx_byte_fifo.sv
// Captures UART receiver bytes at end of frame and buffers them in a show-ahead FIFO.
// Optional build macro RX_FIFO_OVERWRITE_EN: when full, a new byte replaces the oldest one.
module rx_byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_bussy,
   input  logic          rd_ready,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic [AW:0]   level,
   output logic          full,
   output logic          overflow,
   input  logic          clr_ovf
);

   localparam int unsigned DW = 8;
   localparam int unsigned LW = AW + 1;

   localparam logic [2:0] S_ARM    = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_BUSY   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_PUSH   = 3'd4;

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic          w_hold_ld;
   logic          w_push;
   logic [DW-1:0] r_hold;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_valid;
   logic          r_full;
   logic          r_ovf;

   logic          w_pop;
   logic          w_wr;
   logic          w_ovf_set;
   logic [AW-1:0] w_wr_ptr_nxt;
   logic [AW-1:0] w_rd_ptr_nxt;
   logic [LW-1:0] w_level_nxt;

   // Capture FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_ARM;
      else        r_state <= w_state_nxt;
   end

   // S_ARM swallows a frame already in progress when reset is released
   always_comb begin
      w_state_nxt = r_state;
      w_hold_ld   = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_ARM:    if (!rx_bussy) w_state_nxt = S_IDLE;
         S_IDLE:   if (rx_bussy)  w_state_nxt = S_BUSY;
         S_BUSY:   if (!rx_bussy) w_state_nxt = S_SETTLE;
         S_SETTLE: begin
            w_hold_ld   = 1'b1;
            w_state_nxt = S_PUSH;
         end
         S_PUSH: begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_ARM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_hold <= '0;
      else if (w_hold_ld) r_hold <= rx_data;
   end

   assign w_pop = r_valid & rd_ready;

   // Pointer/level update; a simultaneous pop frees the slot for a push at full
   always_comb begin
      w_wr         = 1'b0;
      w_ovf_set    = 1'b0;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_level_nxt  = r_level;
      if (w_pop) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      if (w_push) begin
         if (!r_full || w_pop) begin
            w_wr         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
         end else begin
            w_ovf_set = 1'b1;
`ifdef RX_FIFO_OVERWRITE_EN
            w_wr         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
`endif
         end
      end
      if (w_push && !w_pop && !r_full) w_level_nxt = r_level + LW'(1);
      else if (w_pop && !w_push)       w_level_nxt = r_level - LW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_valid  <= 1'b0;
         r_full   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         r_valid  <= (w_level_nxt != '0);
         r_full   <= (w_level_nxt == LW'(DEPTH));
         if (w_ovf_set)    r_ovf <= 1'b1;
         else if (clr_ovf) r_ovf <= 1'b0;
      end
   end

   // Storage has no reset
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_hold;
   end

   assign rd_data  = r_mem[r_rd_ptr];
   assign rd_valid = r_valid;
   assign level    = r_level;
   assign full     = r_full;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo; expectations follow RX_FIFO_OVERWRITE_EN when defined.
module tb_rx_byte_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_bussy;
   logic          rd_ready;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [AW:0]   level;
   logic          full;
   logic          overflow;
   logic          clr_ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   rx_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_bussy (rx_bussy),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .level    (level),
      .full     (full),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole frame: busy for 'width' cycles, then three edges until the byte is stored
   task automatic frame(input logic [7:0] d, input int width);
      rx_data  = d;
      rx_bussy = 1'b1;
      tick(width);
      rx_bussy = 1'b0;
      tick(3);
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 16; i++) frame(base + 8'(i), 1);
   endtask

   task automatic pop1;
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] e;
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_bussy = 1'b0;
      rd_ready = 1'b0;
      clr_ovf  = 1'b0;
      tick(2);
      chk("rst_level",    32'(level),    32'd0);
      chk("rst_valid",    32'(rd_valid), 32'd0);
      chk("rst_full",     32'(full),     32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single frame with exact latency, rx_data changed after capture
      rx_data  = 8'hA5;
      rx_bussy = 1'b1;
      tick(20);
      rx_bussy = 1'b0;
      tick(1);
      chk("lat_n",   32'(rd_valid), 32'd0);
      tick(1);
      chk("lat_n1",  32'(rd_valid), 32'd0);
      rx_data = 8'hFF;
      tick(1);
      chk("lat_n2",  32'(rd_valid), 32'd1);
      chk("a5_data", 32'(rd_data),  32'hA5);
      chk("a5_lvl",  32'(level),    32'd1);
      pop1();
      chk("a5_pop_lvl",   32'(level),    32'd0);
      chk("a5_pop_valid", 32'(rd_valid), 32'd0);
      pop1();
      chk("empty_pop_lvl", 32'(level), 32'd0);

      // Reset in the middle of a frame must not produce a push
      rx_data  = 8'h99;
      rx_bussy = 1'b1;
      tick(3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(5);
      rx_bussy = 1'b0;
      tick(5);
      chk("midrst_lvl",   32'(level),    32'd0);
      chk("midrst_valid", 32'(rd_valid), 32'd0);
      frame(8'h3C, 10);
      chk("3c_lvl",  32'(level),   32'd1);
      chk("3c_data", 32'(rd_data), 32'h3C);
      pop1();

      // Fill, partial drain, refill across the pointer wrap
      fill(8'h00);
      chk("fill_full", 32'(full),    32'd1);
      chk("fill_lvl",  32'(level),   32'd16);
      chk("fill_head", 32'(rd_data), 32'h00);
      for (int i = 0; i < 4; i++) pop1();
      chk("pop4_lvl",  32'(level),   32'd12);
      chk("pop4_head", 32'(rd_data), 32'h04);
      for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 2);
      chk("wrap_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("wrap_order", 32'(rd_data), 32'(8'h04 + 8'(i)));
         pop1();
      end
      chk("wrap_empty", 32'(rd_valid), 32'd0);
      chk("wrap_ovf",   32'(overflow), 32'd0);

      // Push into a full FIFO with no pop
      fill(8'h00);
      frame(8'hEE, 1);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_lvl", 32'(level),    32'd16);
`ifdef RX_FIFO_OVERWRITE_EN
      chk("ovf_head", 32'(rd_data), 32'h01);
`else
      chk("ovf_head", 32'(rd_data), 32'h00);
`endif
      for (int i = 0; i < 16; i++) begin
`ifdef RX_FIFO_OVERWRITE_EN
         e = (i < 15) ? 8'h01 + 8'(i) : 8'hEE;
`else
         e = 8'(i);
`endif
         chk("ovf_drain", 32'(rd_data), 32'(e));
         pop1();
      end
      chk("ovf_empty", 32'(level), 32'd0);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);

      // Push and pop together at full
      fill(8'h00);
      rx_data  = 8'h55;
      rx_bussy = 1'b1;
      tick(1);
      rx_bussy = 1'b0;
      tick(2);
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
      chk("pp_lvl",  32'(level),    32'd16);
      chk("pp_ovf",  32'(overflow), 32'd0);
      chk("pp_head", 32'(rd_data),  32'h01);

      // Clear in the same cycle as an overflow event: set wins
      rx_data  = 8'h77;
      rx_bussy = 1'b1;
      tick(1);
      rx_bussy = 1'b0;
      tick(2);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("setwin_ovf", 32'(overflow), 32'd1);
      chk("setwin_lvl", 32'(level),    32'd16);
      for (int i = 0; i < 16; i++) begin
`ifdef RX_FIFO_OVERWRITE_EN
         e = (i < 14) ? 8'h02 + 8'(i) : ((i == 14) ? 8'h55 : 8'h77);
`else
         e = (i < 15) ? 8'h01 + 8'(i) : 8'h55;
`endif
         chk("pp_drain", 32'(rd_data), 32'(e));
         pop1();
      end
      chk("pp_empty", 32'(rd_valid), 32'd0);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;

      // One-cycle busy pulse gives exactly one push
      frame(8'h81, 1);
      chk("pulse_lvl",  32'(level),   32'd1);
      chk("pulse_data", 32'(rd_data), 32'h81);
      tick(6);
      chk("pulse_once", 32'(level),   32'd1);
      pop1();
      chk("pulse_empty", 32'(level),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
